// File: rtl/boreal_sram_port_arb_pkg.sv
// Shared constants for the SRAM port arbiter: FSM encodings, bus error data, widths.
package boreal_sram_port_arb_pkg;

  localparam logic [1:0] ARB_ST_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ST_ISSUE = 2'd1;
  localparam logic [1:0] ARB_ST_WAIT  = 2'd2;

  localparam logic [31:0] BOREAL_BUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int unsigned BOREAL_SRAM_AW = 10;
  localparam int unsigned BOREAL_SRAM_DW = 32;

endpackage

// File: rtl/boreal_sram_port_arb_if.sv
// Bus bundle between the two masters, the arbiter and the SRAM tile.
// The slave modport is the arbiter's view; master is the surrounding system.
interface boreal_sram_port_arb_if
  import boreal_sram_port_arb_pkg::*;
#(
  parameter int unsigned AW = BOREAL_SRAM_AW,
  parameter int unsigned DW = BOREAL_SRAM_DW
);

  logic          m0_sel;
  logic          m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_err;

  logic          m1_sel;
  logic          m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          m1_err;

  logic          s_sel;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ack;

  modport slave (
    input  m0_sel, m0_wr, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_sel, m1_wr, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output s_sel, s_wr, s_addr, s_wdata,
    input  s_rdata, s_ack
  );

  modport master (
    output m0_sel, m0_wr, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_sel, m1_wr, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  s_sel, s_wr, s_addr, s_wdata,
    output s_rdata, s_ack
  );

endinterface

// File: rtl/boreal_sram_port_arb_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the master that was not granted last.
module boreal_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       valid_o,
  output logic       idx_o
);

  // Grant selection
  always_comb begin
    valid_o = |req_i;
    if (&req_i) idx_o = ~last_i;
    else        idx_o = req_i[1];
  end

endmodule

// File: rtl/boreal_sram_port_arb.sv
// Two-master, one-slave SRAM port arbiter with round-robin fairness and a
// bus watchdog that converts a hung tile into an error completion.
module boreal_sram_port_arb
  import boreal_sram_port_arb_pkg::*;
#(
  parameter int unsigned AW      = BOREAL_SRAM_AW,
  parameter int unsigned DW      = BOREAL_SRAM_DW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  boreal_sram_port_arb_if.slave   bus,
  output logic                    busy,
  output logic                    owner
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic          wr_q,    wr_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic          gnt_valid;
  logic          gnt_idx;
  logic          done_ok;
  logic          done_to;
  logic [DW-1:0] resp_data;

  boreal_rr_arb2 u_rr (
    .req_i   ({bus.m1_sel, bus.m0_sel}),
    .last_i  (last_q),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  // Completion detection: a tile ack beats the watchdog terminal count
  always_comb begin
    done_ok = (state_q == ARB_ST_WAIT) && bus.s_ack;
    done_to = (state_q == ARB_ST_WAIT) && !bus.s_ack && (cnt_q == CW'(TIMEOUT - 1));
  end

  // Next-state logic: grant, issue, then wait for ack or watchdog expiry
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          wr_d    = gnt_idx ? bus.m1_wr    : bus.m0_wr;
          addr_d  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
          wdata_d = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
          state_d = ARB_ST_ISSUE;
        end
      end
      ARB_ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_ST_WAIT;
      end
      ARB_ST_WAIT: begin
        if (done_ok || done_to) state_d = ARB_ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ARB_ST_IDLE;
    endcase
  end

  // State and request latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response routing: only the owner sees ack/err/rdata, and only in WAIT
  always_comb begin
    resp_data = '0;
    if (done_ok)      resp_data = wr_q ? '0 : bus.s_rdata;
    else if (done_to) resp_data = DW'(BOREAL_BUS_ERR_DATA);
    bus.m0_ack   = (done_ok || done_to) && !owner_q;
    bus.m0_err   = done_to && !owner_q;
    bus.m0_rdata = owner_q ? '0 : resp_data;
    bus.m1_ack   = (done_ok || done_to) && owner_q;
    bus.m1_err   = done_to && owner_q;
    bus.m1_rdata = owner_q ? resp_data : '0;
  end

  // Tile-side request and status outputs
  always_comb begin
    bus.s_sel   = (state_q == ARB_ST_ISSUE);
    bus.s_wr    = wr_q;
    bus.s_addr  = addr_q;
    bus.s_wdata = wdata_q;
    busy        = (state_q != ARB_ST_IDLE);
    owner       = owner_q;
  end

endmodule
